// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   Bundles the BCD input side and the segment/anode pin side of the
//   four-digit scan driver.
//
//   Handshake: bcd_valid is a single-cycle strobe with no ready. The display
//   always accepts it: bcd is captured on any rising clock edge where
//   bcd_valid is high. Strobes arriving before an earlier value reaches the
//   display overwrite that value.
//
//   Signals
//     bcd       [15:0] packed BCD word, [3:0] units .. [15:12] thousands
//     bcd_valid        load strobe for bcd
//     blank_en         1 = blank leading zeros, sampled every cycle
//     seg       [6:0]  {g,f,e,d,c,b,a}, active-low
//     an        [3:0]  digit anodes, active-low, an[0] = units digit
//
//   Modports
//     master : the producer and board side (drives bcd/bcd_valid/blank_en)
//     slave  : the scan driver (drives seg/an)
interface seg7_scan_display_if;
    logic [15:0] bcd;
    logic        bcd_valid;
    logic        blank_en;
    logic [6:0]  seg;
    logic [3:0]  an;

    modport master (
        output bcd,
        output bcd_valid,
        output blank_en,
        input  seg,
        input  an
    );

    modport slave (
        input  bcd,
        input  bcd_valid,
        input  blank_en,
        output seg,
        output an
    );
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   A new BCD word is parked in a shadow register and only copied to the
//   displayed word at a frame boundary (digit index wrapping 3 -> 0), so a
//   frame never mixes digits from two different words.
//
//   Parameters
//     SCAN_DIV  clock cycles per digit slot (>= 2)
//
//   Ports
//     clk   system clock, rising edge
//     rst   asynchronous, active-high reset; blanks the outputs immediately
//     bus   seg7_scan_display_if.slave (bcd, bcd_valid, blank_en in;
//           seg, an out, both registered)
module seg7_scan_display #(
    parameter int SCAN_DIV = 100000
) (
    input logic                clk,
    input logic                rst,
    seg7_scan_display_if.slave bus
);

    localparam int             PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0] pre;
    logic [1:0]       idx;
    logic             tick;
    logic             frame_end;

    logic [15:0]      shadow;
    logic [15:0]      disp;
    logic             pending;

    logic [3:0]       nibble;
    logic             upper_zero;
    logic             blank;
    logic [6:0]       seg_next;

    logic [6:0]       seg_q;
    logic [3:0]       an_q;

    // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign tick      = (pre == PRE_LAST);
    assign frame_end = tick && (idx == 2'd3);

    // Prescaler and digit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre <= '0;
            idx <= 2'd0;
        end else if (tick) begin
            pre <= '0;
            idx <= idx + 2'd1;
        end else begin
            pre <= pre + PRE_W'(1);
        end
    end

    // Shadow/display words. When a strobe lands on the frame-end edge, disp
    // takes the old shadow and the new word stays pending for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow  <= 16'h0000;
            disp    <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                disp <= shadow;
            end
            if (bus.bcd_valid) begin
                shadow  <= bus.bcd;
                pending <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end
        end
    end

    // Digit select and leading-zero blanking. A digit is blanked only when it
    // and every more significant nibble are zero; digit 0 is always lit.
    always_comb begin
        nibble     = disp[{idx, 2'b00} +: 4];
        upper_zero = 1'b0;
        case (idx)
            2'd3:    upper_zero = (disp[15:12] == 4'h0);
            2'd2:    upper_zero = (disp[15:8]  == 8'h00);
            2'd1:    upper_zero = (disp[15:4]  == 12'h000);
            default: upper_zero = 1'b0;
        endcase
        blank    = bus.blank_en && upper_zero;
        seg_next = blank ? 7'b1111111 : decode(nibble);
    end

    // Registered pin drivers; reset forces all segments and anodes off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q <= 7'b1111111;
            an_q  <= 4'b1111;
        end else begin
            seg_q <= seg_next;
            an_q  <= ~(4'b0001 << idx);
        end
    end

    assign bus.seg = seg_q;
    assign bus.an  = an_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// tb_seg7_scan_display
//   Bench for seg7_scan_display with SCAN_DIV = 4. A reference model counts
//   edges since reset and derives the digit slot and frame boundaries from
//   that count; a negedge process compares seg/an against it every cycle.
//   Directed scenarios add literal segment/anode expectations.
module tb_seg7_scan_display;

    localparam int SD    = 4;
    localparam int FRAME = 4 * SD;

    logic clk;
    logic rst;

    seg7_scan_display_if u_if ();

    seg7_scan_display #(.SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    int n_checks;
    int n_fail;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference tables ----------------
    logic [6:0] seg_tab [16];
    logic [3:0] an_tab  [4];
    logic [6:0] seg_blank;
    logic [6:0] seg_dash;

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;
        an_tab[0] = 4'b1110; an_tab[1] = 4'b1101;
        an_tab[2] = 4'b1011; an_tab[3] = 4'b0111;
        seg_blank = 7'b1111111;
        seg_dash  = 7'b0111111;
    end

    // ---------------- behavioural model ----------------
    // Inputs as seen at the most recent rising edge.
    logic        s_valid;
    logic [15:0] s_bcd;
    logic        s_blank;
    logic        s_rst;

    always @(posedge clk) begin
        s_valid <= u_if.bcd_valid;
        s_bcd   <= u_if.bcd;
        s_blank <= u_if.blank_en;
        s_rst   <= rst;
    end

    int          m_cnt;      // rising edges since reset released
    logic [15:0] m_disp;     // word on the display
    logic [15:0] m_latest;   // last strobed word
    logic        m_pending;  // m_latest not yet shown
    logic [3:0]  exp_an;
    logic [6:0]  exp_seg;
    int          slot;

    always @(negedge clk) begin
        if (rst || s_rst) begin
            exp_an    = 4'b1111;
            exp_seg   = 7'b1111111;
            m_cnt     = 0;
            m_disp    = 16'h0000;
            m_latest  = 16'h0000;
            m_pending = 1'b0;
        end else begin
            slot   = (m_cnt / SD) % 4;
            exp_an = an_tab[slot];
            if (s_blank && slot != 0 && (m_disp >> (4 * slot)) == 16'h0000)
                exp_seg = seg_blank;
            else
                exp_seg = seg_tab[(m_disp >> (4 * slot)) & 16'h000f];
            // Last edge of a frame: the display picks up the newest word
            // strobed before this edge.
            if ((m_cnt % FRAME) == FRAME - 1 && m_pending) begin
                m_disp    = m_latest;
                m_pending = 1'b0;
            end
            if (s_valid) begin
                m_latest  = s_bcd;
                m_pending = 1'b1;
            end
            m_cnt++;
        end
        n_checks++;
        if (u_if.an !== exp_an || u_if.seg !== exp_seg) begin
            n_fail++;
            $display("FAIL scan_cycle t=%0t: an=%b seg=%b, expected an=%b seg=%b",
                     $time, u_if.an, u_if.seg, exp_an, exp_seg);
        end
    end

    // ---------------- driver tasks ----------------
    // All driving happens 1 time unit after a falling edge, after the
    // model update for the preceding rising edge has completed.
    task automatic wait_phase(input int p);
        int k;
        k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while ((m_cnt % FRAME) != p && k < 100);
        n_checks++;
        if ((m_cnt % FRAME) != p) begin
            n_fail++;
            $display("FAIL wait_phase: phase=%0d, expected %0d", m_cnt % FRAME, p);
        end
    endtask

    task automatic strobe(input logic [15:0] v);
        u_if.bcd       = v;
        u_if.bcd_valid = 1'b1;
        @(negedge clk); #1;
        u_if.bcd_valid = 1'b0;
    endtask

    task automatic check_lit(input string name, input logic [3:0] e_an, input logic [6:0] e_seg);
        n_checks++;
        if (u_if.an !== e_an || u_if.seg !== e_seg) begin
            n_fail++;
            $display("FAIL %s: an=%b seg=%b, expected an=%b seg=%b",
                     name, u_if.an, u_if.seg, e_an, e_seg);
        end
    endtask

    // Call with the outputs showing the first cycle of a frame.
    task automatic check_frame(input string name, input logic [6:0] d0, input logic [6:0] d1,
                               input logic [6:0] d2, input logic [6:0] d3);
        logic [6:0] e;
        for (int i = 0; i < FRAME; i++) begin
            case (i / SD)
                0:       e = d0;
                1:       e = d1;
                2:       e = d2;
                default: e = d3;
            endcase
            check_lit(name, an_tab[i / SD], e);
            @(negedge clk); #1;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [15:0] rv;

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        rst            = 1'b1;
        u_if.bcd       = 16'h0000;
        u_if.bcd_valid = 1'b0;
        u_if.blank_en  = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_lit("reset_state", 4'b1111, 7'b1111111);
        rst = 1'b0;
        @(negedge clk); #1;
        check_lit("first_edge", 4'b1110, 7'b1000000);

        // Scan order
        wait_phase(0);
        strobe(16'h1234);
        wait_phase(1);
        check_frame("scan_order", seg_tab[4], seg_tab[3], seg_tab[2], seg_tab[1]);

        // Tear-free update
        wait_phase(0);
        strobe(16'h5678);
        wait_phase(0);
        wait_phase(5);
        strobe(16'h1234);
        wait_phase(9);
        check_lit("tear_digit2", 4'b1011, 7'b0000010);
        wait_phase(13);
        check_lit("tear_digit3", 4'b0111, 7'b0010010);
        wait_phase(0);
        check_lit("tear_last_slot", 4'b0111, 7'b0010010);
        @(negedge clk); #1;
        check_lit("tear_new_word", 4'b1110, 7'b0011001);

        // Leading-zero blanking
        u_if.blank_en = 1'b1;
        wait_phase(0);
        strobe(16'h0050);
        wait_phase(1);
        check_frame("blank_0050", seg_tab[0], seg_tab[5], seg_blank, seg_blank);
        wait_phase(0);
        strobe(16'h0000);
        wait_phase(1);
        check_frame("blank_0000", seg_tab[0], seg_blank, seg_blank, seg_blank);
        wait_phase(9);
        check_lit("blank_digit2_on", 4'b1011, 7'b1111111);
        u_if.blank_en = 1'b0;
        @(negedge clk); #1;
        check_lit("blank_toggle_off", 4'b1011, 7'b1000000);

        // Invalid nibble
        u_if.blank_en = 1'b1;
        wait_phase(0);
        strobe(16'h0A00);
        wait_phase(1);
        check_frame("invalid_nibble", seg_tab[0], seg_tab[0], seg_dash, seg_blank);

        // Strobe on the frame-end edge while a word is pending
        u_if.blank_en = 1'b0;
        wait_phase(3);
        strobe(16'h1111);
        wait_phase(15);
        strobe(16'h9999);
        wait_phase(1);
        check_frame("simul_first", seg_tab[1], seg_tab[1], seg_tab[1], seg_tab[1]);
        check_frame("simul_second", seg_tab[9], seg_tab[9], seg_tab[9], seg_tab[9]);

        // Reset mid-frame with a pending word
        wait_phase(2);
        strobe(16'h4321);
        wait_phase(6);
        rst = 1'b1;
        #1;
        check_lit("async_reset", 4'b1111, 7'b1111111);
        @(negedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        check_frame("post_reset_a", seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[0]);
        check_frame("post_reset_b", seg_tab[0], seg_tab[0], seg_tab[0], seg_tab[0]);

        // Randomized traffic, checked cycle by cycle by the model
        for (int c = 0; c < 800; c++) begin
            rv = 16'($urandom);
            for (int k = 0; k < 4; k++)
                if ($urandom_range(0, 2) == 0) rv[4*k +: 4] = 4'h0;
            u_if.bcd       = rv;
            u_if.bcd_valid = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) u_if.blank_en = ~u_if.blank_en;
            if (c == 400) rst = 1'b1;
            if (c == 403) rst = 1'b0;
            @(negedge clk); #1;
        end
        u_if.bcd_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
